// File: rtl/fetch_stage.sv
`default_nettype none
// ==================================================================================================
// fetch_stage : ARM instruction-fetch front end -- PC, in-order imem requests, response FIFO and
//               Decode register with redirect/discard. Optional macro FETCH_PERF_EN adds counters.
// Revision    : 1.0
// ==================================================================================================
module fetch_stage #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReqFet,
   output logic [31:0] ImemAdrFet,
   input  logic        ImemValid,
   input  logic [31:0] ImemRdata,
   input  logic        StallFet,
   input  logic        StallDec,
   input  logic        FlushDec,
   input  logic        BranchTakenExe,
   input  logic [31:0] ALUResultExe,
   input  logic        PCSrcWri,
   input  logic [31:0] ResultWri,
   output logic [31:0] InstrDec,
   output logic [31:0] PCPlus8Dec,
   output logic        ValidDec
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] FetchCnt,
   output logic [31:0] DropCnt
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = 16;
   localparam logic [CW:0] CREDITS = DEPTH[CW:0];

   logic [31:0]   pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] fifo_count;
   logic [DW-1:0] discard;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_addr  [DEPTH];

   logic [31:0]   instr_dec;
   logic [31:0]   pc8_dec;
   logic          valid_dec;

   logic          redirect;
   logic [31:0]   target;
   logic [CW:0]   credit_used;
   logic          issue;
   logic          resp_drop;
   logic          resp_live;
   logic          dec_load;
   logic          pop;
   logic          bypass;
   logic          push;

   assign redirect    = BranchTakenExe | PCSrcWri;
   assign target      = (BranchTakenExe ? ALUResultExe : ResultWri) & 32'hFFFF_FFFC;

   // inflight counts only live requests; stale ones move to discard on redirect and stop holding credit
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign issue       = !reset && !StallFet && !redirect && (credit_used < CREDITS);

   assign resp_drop   = ImemValid && (discard != '0);
   assign resp_live   = ImemValid && (discard == '0) && (inflight != '0);

   assign dec_load    = !StallDec && !FlushDec && !redirect;
   assign pop         = dec_load && (fifo_count != '0);
   assign bypass      = dec_load && (fifo_count == '0) && resp_live;
   assign push        = resp_live && !redirect && !bypass;

   assign ImemReqFet  = issue;
   assign ImemAdrFet  = pc & 32'hFFFF_FFFC;
   assign InstrDec    = instr_dec;
   assign PCPlus8Dec  = pc8_dec;
   assign ValidDec    = valid_dec;

   // resp_pc tracks the address of the next live response, so the FIFO needs no per-request tag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         resp_pc <= RESET_PC & 32'hFFFF_FFFC;
      end else if (redirect) begin
         pc      <= target;
         resp_pc <= target;
      end else begin
         if (issue)
            pc <= pc + 32'd4;
         if (resp_live)
            resp_pc <= resp_pc + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= '0;
         discard  <= '0;
      end else if (redirect) begin
         inflight <= '0;
         discard  <= discard - DW'(resp_drop) + DW'(inflight) - DW'(resp_live);
      end else begin
         inflight <= inflight + CW'(issue) - CW'(resp_live);
         discard  <= discard - DW'(resp_drop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else if (redirect) begin
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= ImemRdata;
         fifo_addr[wr_ptr]  <= resp_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_dec <= 1'b0;
         instr_dec <= 32'h0;
         pc8_dec   <= 32'h0;
      end else if (redirect || FlushDec) begin
         valid_dec <= 1'b0;
         instr_dec <= 32'h0;
         pc8_dec   <= 32'h0;
      end else if (!StallDec) begin
         if (pop) begin
            valid_dec <= 1'b1;
            instr_dec <= fifo_instr[rd_ptr];
            pc8_dec   <= fifo_addr[rd_ptr] + 32'd8;
         end else if (bypass) begin
            valid_dec <= 1'b1;
            instr_dec <= ImemRdata;
            pc8_dec   <= resp_pc + 32'd8;
         end else begin
            valid_dec <= 1'b0;
            instr_dec <= 32'h0;
            pc8_dec   <= 32'h0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] drop_cnt;
   logic [31:0] drop_inc;

   // a live response landing in a redirect cycle is lost as well, alongside any cleared FIFO entries
   assign drop_inc = 32'(resp_drop) + 32'(redirect && resp_live) + (redirect ? 32'(fifo_count) : 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= 32'h0;
         drop_cnt  <= 32'h0;
      end else begin
         fetch_cnt <= fetch_cnt + 32'(issue);
         drop_cnt  <= drop_cnt + drop_inc;
      end
   end

   assign FetchCnt = fetch_cnt;
   assign DropCnt  = drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Testbench for fetch_stage: directed scenarios against a fixed-latency in-order memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ImemReqFet;
   logic [31:0] ImemAdrFet;
   logic        ImemValid;
   logic [31:0] ImemRdata;
   logic        StallFet, StallDec, FlushDec;
   logic        BranchTakenExe, PCSrcWri;
   logic [31:0] ALUResultExe, ResultWri;
   logic [31:0] InstrDec, PCPlus8Dec;
   logic        ValidDec;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCnt, DropCnt;
`endif

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          lat;
   int          n_req;
   logic        req_seen;
   logic [31:0] adr_seen;
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   always #5 clk = ~clk;

   fetch_stage #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .ImemReqFet(ImemReqFet), .ImemAdrFet(ImemAdrFet),
      .ImemValid(ImemValid), .ImemRdata(ImemRdata),
      .StallFet(StallFet), .StallDec(StallDec), .FlushDec(FlushDec),
      .BranchTakenExe(BranchTakenExe), .ALUResultExe(ALUResultExe),
      .PCSrcWri(PCSrcWri), .ResultWri(ResultWri),
      .InstrDec(InstrDec), .PCPlus8Dec(PCPlus8Dec), .ValidDec(ValidDec)
`ifdef FETCH_PERF_EN
      , .FetchCnt(FetchCnt), .DropCnt(DropCnt)
`endif
   );

   // one clock: sample the request at negedge, then advance memory model after posedge
   task automatic step();
      @(negedge clk);
      req_seen = ImemReqFet;
      adr_seen = ImemAdrFet;
      if (req_seen) n_req++;
      @(posedge clk);
      #1;
      if (ImemValid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (req_seen) begin
         mq_addr.push_back(adr_seen);
         mq_due.push_back(cyc + lat);
      end
      cyc++;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         ImemValid = 1'b1;
         ImemRdata = ~mq_addr[0];
      end else begin
         ImemValid = 1'b0;
         ImemRdata = 32'h0;
      end
   endtask

   task automatic clear_inputs();
      StallFet = 0; StallDec = 0; FlushDec = 0;
      BranchTakenExe = 0; PCSrcWri = 0; ALUResultExe = 0; ResultWri = 0;
      ImemValid = 0; ImemRdata = 0;
      mq_addr.delete(); mq_due.delete();
   endtask

   task automatic do_reset(input int l);
      reset = 1'b1;
      clear_inputs();
      lat = l;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      cyc = 0; n_req = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      @(posedge clk); @(posedge clk); #1;
      checks++; if (ImemReqFet !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ImemReqFet); end
      checks++; if (ImemAdrFet !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 00000000", ImemAdrFet); end
      checks++; if (ValidDec !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidDec); end
      checks++; if (InstrDec !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", InstrDec); end
      checks++; if (PCPlus8Dec !== 32'h0) begin errors++; $display("FAIL reset_pc8 got %h exp 00000000", PCPlus8Dec); end
   endtask

   task automatic test_sequential();
      do_reset(1);
      step();
      checks++; if (req_seen !== 1'b1 || adr_seen !== 32'h0) begin errors++; $display("FAIL seq_adr0 got req=%b adr=%h exp req=1 adr=00000000", req_seen, adr_seen); end
      checks++; if (ValidDec !== 1'b0) begin errors++; $display("FAIL seq_valid_c1 got %b exp 0", ValidDec); end
      step();
      checks++; if (adr_seen !== 32'h4) begin errors++; $display("FAIL seq_adr4 got %h exp 00000004", adr_seen); end
      checks++; if (ValidDec !== 1'b1 || InstrDec !== 32'hFFFF_FFFF || PCPlus8Dec !== 32'h8) begin errors++; $display("FAIL seq_dec0 got v=%b i=%h p=%h exp v=1 i=ffffffff p=00000008", ValidDec, InstrDec, PCPlus8Dec); end
      step();
      checks++; if (adr_seen !== 32'h8) begin errors++; $display("FAIL seq_adr8 got %h exp 00000008", adr_seen); end
      checks++; if (InstrDec !== 32'hFFFF_FFFB || PCPlus8Dec !== 32'hC) begin errors++; $display("FAIL seq_dec4 got i=%h p=%h exp i=fffffffb p=0000000c", InstrDec, PCPlus8Dec); end
      step();
      checks++; if (ValidDec !== 1'b1 || PCPlus8Dec !== 32'h10) begin errors++; $display("FAIL seq_dec8 got v=%b p=%h exp v=1 p=00000010", ValidDec, PCPlus8Dec); end
   endtask

   task automatic test_credit_stall();
      do_reset(3);
      StallDec = 1'b1;
      for (int i = 0; i < 10; i++) step();
      checks++; if (n_req !== 4) begin errors++; $display("FAIL credit_count got %0d exp 4", n_req); end
      checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL credit_req_off got %b exp 0", req_seen); end
      checks++; if (ValidDec !== 1'b0) begin errors++; $display("FAIL credit_dec_held got %b exp 0", ValidDec); end
      StallDec = 1'b0;
      step();
      checks++; if (req_seen !== 1'b0 || ValidDec !== 1'b1 || InstrDec !== 32'hFFFF_FFFF || PCPlus8Dec !== 32'h8) begin errors++; $display("FAIL credit_release got req=%b v=%b i=%h p=%h exp req=0 v=1 i=ffffffff p=00000008", req_seen, ValidDec, InstrDec, PCPlus8Dec); end
      step();
      checks++; if (req_seen !== 1'b1 || adr_seen !== 32'h10 || InstrDec !== 32'hFFFF_FFFB) begin errors++; $display("FAIL credit_resume got req=%b adr=%h i=%h exp req=1 adr=00000010 i=fffffffb", req_seen, adr_seen, InstrDec); end
   endtask

   task automatic test_branch_discard();
      do_reset(2);
      for (int i = 0; i < 16; i++) step();
      checks++; if (adr_seen !== 32'h3C) begin errors++; $display("FAIL br_pre_adr got %h exp 0000003c", adr_seen); end
      BranchTakenExe = 1'b1; ALUResultExe = 32'h100;
      step();
      BranchTakenExe = 1'b0; ALUResultExe = 32'h0;
      checks++; if (req_seen !== 1'b0 || ValidDec !== 1'b0) begin errors++; $display("FAIL br_redirect_cycle got req=%b v=%b exp req=0 v=0", req_seen, ValidDec); end
      step();
      checks++; if (req_seen !== 1'b1 || adr_seen !== 32'h100) begin errors++; $display("FAIL br_target_adr got req=%b adr=%h exp req=1 adr=00000100", req_seen, adr_seen); end
      for (int i = 0; i < 10 && ValidDec !== 1'b1; i++) step();
      checks++; if (ValidDec !== 1'b1 || InstrDec !== 32'hFFFF_FEFF || PCPlus8Dec !== 32'h108) begin errors++; $display("FAIL br_first_instr got v=%b i=%h p=%h exp v=1 i=fffffeff p=00000108", ValidDec, InstrDec, PCPlus8Dec); end
`ifdef FETCH_PERF_EN
      checks++; if (DropCnt !== 32'd2) begin errors++; $display("FAIL perf_drop got %0d exp 2", DropCnt); end
      checks++; if (FetchCnt !== 32'(n_req)) begin errors++; $display("FAIL perf_fetch got %0d exp %0d", FetchCnt, n_req); end
`endif
   endtask

   task automatic test_dual_redirect();
      do_reset(1);
      for (int i = 0; i < 3; i++) step();
      BranchTakenExe = 1'b1; ALUResultExe = 32'h200;
      PCSrcWri = 1'b1; ResultWri = 32'h300;
      step();
      BranchTakenExe = 1'b0; PCSrcWri = 1'b0;
      step();
      checks++; if (adr_seen !== 32'h200) begin errors++; $display("FAIL dual_adr got %h exp 00000200", adr_seen); end
      for (int i = 0; i < 10 && ValidDec !== 1'b1; i++) step();
      checks++; if (InstrDec !== 32'hFFFF_FDFF || PCPlus8Dec !== 32'h208) begin errors++; $display("FAIL dual_instr got i=%h p=%h exp i=fffffdff p=00000208", InstrDec, PCPlus8Dec); end
   endtask

   task automatic test_flush_stall();
      do_reset(1);
      for (int i = 0; i < 3; i++) step();
      FlushDec = 1'b1; StallDec = 1'b1;
      step();
      FlushDec = 1'b0; StallDec = 1'b0;
      checks++; if (ValidDec !== 1'b0 || InstrDec !== 32'h0) begin errors++; $display("FAIL flush_bubble got v=%b i=%h exp v=0 i=00000000", ValidDec, InstrDec); end
      step();
      checks++; if (ValidDec !== 1'b1 || InstrDec !== 32'hFFFF_FFF7 || PCPlus8Dec !== 32'h10) begin errors++; $display("FAIL flush_next got v=%b i=%h p=%h exp v=1 i=fffffff7 p=00000010", ValidDec, InstrDec, PCPlus8Dec); end
      step();
      checks++; if (InstrDec !== 32'hFFFF_FFF3 || PCPlus8Dec !== 32'h14) begin errors++; $display("FAIL flush_after got i=%h p=%h exp i=fffffff3 p=00000014", InstrDec, PCPlus8Dec); end
   endtask

   task automatic test_wrap();
      do_reset(1);
      PCSrcWri = 1'b1; ResultWri = 32'hFFFF_FFFF;
      step();
      PCSrcWri = 1'b0; ResultWri = 32'h0;
      checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL wrap_redirect_req got %b exp 0", req_seen); end
      step();
      checks++; if (adr_seen !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", adr_seen); end
      step();
      checks++; if (adr_seen !== 32'h0) begin errors++; $display("FAIL wrap_adr got %h exp 00000000", adr_seen); end
      checks++; if (ValidDec !== 1'b1 || InstrDec !== 32'h3 || PCPlus8Dec !== 32'h4) begin errors++; $display("FAIL wrap_dec got v=%b i=%h p=%h exp v=1 i=00000003 p=00000004", ValidDec, InstrDec, PCPlus8Dec); end
   endtask

   task automatic test_stall_fet();
      do_reset(1);
      StallFet = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++; if (n_req !== 0) begin errors++; $display("FAIL stallfet_hold got %0d reqs exp 0", n_req); end
      StallFet = 1'b0;
      step();
      checks++; if (req_seen !== 1'b1 || adr_seen !== 32'h0) begin errors++; $display("FAIL stallfet_resume got req=%b adr=%h exp req=1 adr=00000000", req_seen, adr_seen); end
      StallFet = 1'b1; BranchTakenExe = 1'b1; ALUResultExe = 32'h80;
      step();
      BranchTakenExe = 1'b0;
      step();
      checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL stallfet_redirect_req got %b exp 0", req_seen); end
      StallFet = 1'b0;
      step();
      checks++; if (adr_seen !== 32'h80) begin errors++; $display("FAIL stallfet_redirect_adr got %h exp 00000080", adr_seen); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_credit_stall();
      test_branch_discard();
      test_dual_redirect();
      test_flush_stall();
      test_wrap();
      test_stall_fet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
